python_sync_decode: RTL

PYTHON_SYNC_DECODE -- requirements
Module: python_sync_decode

---
 rtl/python_sync_pkg.sv | 23 ++
 rtl/python_word_align.sv | 118 +++++++++++
 rtl/python_sync_decode.sv | 124 ++++++++++++
 3 files changed

// File: rtl/python_sync_pkg.sv
// python_sync_pkg
//   Shared definitions for the Python image-sensor sync decoder:
//   - default 10-bit sync code values carried on the sync channel
//   - state encoding of the word-alignment FSM
package python_sync_pkg;

    localparam logic [9:0] SYNC_TR  = 10'h3A6;  // training pattern
    localparam logic [9:0] SYNC_FS  = 10'h2AA;  // frame start
    localparam logic [9:0] SYNC_FE  = 10'h3AA;  // frame end
    localparam logic [9:0] SYNC_LS  = 10'h0AA;  // line start
    localparam logic [9:0] SYNC_LE  = 10'h12A;  // line end
    localparam logic [9:0] SYNC_BL  = 10'h015;  // black pixels
    localparam logic [9:0] SYNC_IMG = 10'h035;  // valid image pixels
    localparam logic [9:0] SYNC_CRC = 10'h059;  // CRC word

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

endpackage

// File: rtl/python_word_align.sv
// python_word_align
//   Word-alignment FSM for the sync channel. Counts consecutive training
//   words to declare lock, requests a bitslip on a bad word while searching,
//   waits for the deserializer to settle, and drops lock after a run of
//   illegal sync words.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   word_en  in   a valid word is present this cycle
//   is_tr    in   sync word equals the training code
//   is_legal in   sync word is one of the known sync codes
//   bitslip  out  one-cycle bitslip request (state SLIP)
//   aligned  out  lock achieved (state LOCKED)
//   unlock   out  combinational: this word's update drops lock
module python_word_align
    import python_sync_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned SLIP_WAIT = 4,
    parameter int unsigned ERR_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic word_en,
    input  logic is_tr,
    input  logic is_legal,
    output logic bitslip,
    output logic aligned,
    output logic unlock
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
    localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

    align_state_t  state, state_nx;
    logic [MW-1:0] match_cnt, match_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [EW-1:0] err_cnt, err_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SEARCH;
            match_cnt <= '0;
            wait_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            match_cnt <= match_nx;
            wait_cnt  <= wait_nx;
            err_cnt   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        wait_nx  = wait_cnt;
        err_nx   = err_cnt;
        unlock   = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (word_en) begin
                    if (is_tr) begin
                        // Counter parks at LOCK_CNT on lock; cleared again on re-entry to SEARCH.
                        if (match_cnt >= MW'(LOCK_CNT - 1)) begin
                            state_nx = ST_LOCKED;
                            match_nx = MW'(LOCK_CNT);
                            err_nx   = '0;
                        end else begin
                            match_nx = match_cnt + 1'b1;
                        end
                    end else begin
                        match_nx = '0;
                        state_nx = ST_SLIP;
                    end
                end
            end
            // SLIP lasts exactly one clock regardless of word_en.
            ST_SLIP: begin
                state_nx = ST_WAIT;
                wait_nx  = '0;
            end
            ST_WAIT: begin
                if (word_en) begin
                    if (wait_cnt >= WW'(SLIP_WAIT - 1)) begin
                        state_nx = ST_SEARCH;
                        match_nx = '0;
                        wait_nx  = '0;
                    end else begin
                        wait_nx = wait_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (word_en) begin
                    if (is_legal) begin
                        err_nx = '0;
                    end else if (err_cnt >= EW'(ERR_LIMIT - 1)) begin
                        unlock   = 1'b1;
                        state_nx = ST_SEARCH;
                        match_nx = '0;
                        err_nx   = '0;
                    end else begin
                        err_nx = err_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_SEARCH;
        endcase
    end

    always_comb begin
        bitslip = (state == ST_SLIP);
        aligned = (state == ST_LOCKED);
    end

endmodule

// File: rtl/python_sync_decode.sv
// python_sync_decode
//   Sync-channel decoder for a Python image sensor LVDS interface. Aligns
//   the deserializer using the training pattern, then decodes frame/line
//   sync codes into fval/lval and registers image pixel words.
//   Optional build macro PYTHON_SYNC_ERR_CNT_EN adds ov_err_cnt, a
//   saturating count of illegal sync words seen while locked.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   i_word_en     in   valid deserialized word set this cycle
//   iv_ctrl_word  in   sync channel word
//   iv_data_word  in   data channel words, channel 0 in LSBs
//   o_bitslip     out  one-cycle bitslip request
//   o_aligned     out  word alignment locked
//   o_fval        out  frame valid
//   o_lval        out  line valid
//   o_pix_en      out  ov_pix_data valid (single-cycle pulse)
//   ov_pix_data   out  registered pixel words
//   ov_err_cnt    out  illegal sync word count (PYTHON_SYNC_ERR_CNT_EN only)
module python_sync_decode
    import python_sync_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned SLIP_WAIT   = 4,
    parameter int unsigned ERR_LIMIT   = 8,
    parameter logic [DATA_WIDTH-1:0] TR  = DATA_WIDTH'(SYNC_TR),
    parameter logic [DATA_WIDTH-1:0] FS  = DATA_WIDTH'(SYNC_FS),
    parameter logic [DATA_WIDTH-1:0] FE  = DATA_WIDTH'(SYNC_FE),
    parameter logic [DATA_WIDTH-1:0] LS  = DATA_WIDTH'(SYNC_LS),
    parameter logic [DATA_WIDTH-1:0] LE  = DATA_WIDTH'(SYNC_LE),
    parameter logic [DATA_WIDTH-1:0] BL  = DATA_WIDTH'(SYNC_BL),
    parameter logic [DATA_WIDTH-1:0] IMG = DATA_WIDTH'(SYNC_IMG),
    parameter logic [DATA_WIDTH-1:0] CRC = DATA_WIDTH'(SYNC_CRC)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_word_en,
    input  logic [DATA_WIDTH-1:0]             iv_ctrl_word,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] iv_data_word,
    output logic                              o_bitslip,
    output logic                              o_aligned,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic                              o_pix_en,
    output logic [CHANNEL_NUM*DATA_WIDTH-1:0] ov_pix_data
`ifdef PYTHON_SYNC_ERR_CNT_EN
    ,
    output logic [15:0]                       ov_err_cnt
`endif
);

    logic is_tr;
    logic is_legal;
    logic unlock;

    always_comb begin
        is_tr    = (iv_ctrl_word == TR);
        is_legal = (iv_ctrl_word inside {TR, FS, FE, LS, LE, BL, IMG, CRC});
    end

    python_word_align #(
        .LOCK_CNT  (LOCK_CNT),
        .SLIP_WAIT (SLIP_WAIT),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_word_align (
        .clk      (clk),
        .reset    (reset),
        .word_en  (i_word_en),
        .is_tr    (is_tr),
        .is_legal (is_legal),
        .bitslip  (o_bitslip),
        .aligned  (o_aligned),
        .unlock   (unlock)
    );

    // Decoding acts only while already LOCKED; the unlock update forces
    // the video flags low on the same edge the FSM leaves LOCKED.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_fval      <= 1'b0;
            o_lval      <= 1'b0;
            o_pix_en    <= 1'b0;
            ov_pix_data <= '0;
        end else begin
            o_pix_en <= 1'b0;
            if (i_word_en && o_aligned) begin
                if (unlock) begin
                    o_fval <= 1'b0;
                    o_lval <= 1'b0;
                end else if (iv_ctrl_word == FS) begin
                    o_fval <= 1'b1;
                    o_lval <= 1'b1;
                end else if (iv_ctrl_word == LS) begin
                    if (o_fval) begin
                        o_lval <= 1'b1;
                    end
                end else if (iv_ctrl_word == LE) begin
                    o_lval <= 1'b0;
                end else if (iv_ctrl_word == FE) begin
                    o_fval <= 1'b0;
                    o_lval <= 1'b0;
                end else if (iv_ctrl_word == IMG) begin
                    if (o_lval) begin
                        o_pix_en    <= 1'b1;
                        ov_pix_data <= iv_data_word;
                    end
                end
            end
        end
    end

`ifdef PYTHON_SYNC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_err_cnt <= '0;
        end else if (i_word_en && o_aligned && !is_legal && (ov_err_cnt != '1)) begin
            ov_err_cnt <= ov_err_cnt + 16'd1;
        end
    end
`endif

endmodule
